// File: rtl/h_alpha_stream_src_pkg.sv
// Shared encodings for the H/alpha stream source and its downstream consumer.
package h_alpha_stream_src_pkg;

  // FSM state encoding (kept as plain constants for legacy consumers).
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEND_H = 2'd1;
  localparam state_t ST_SEND_A = 2'd2;
  localparam state_t ST_FIN    = 2'd3;

  // cfg_sel encodings.
  typedef logic sel_t;

  localparam sel_t SEL_H     = 1'b0;
  localparam sel_t SEL_ALPHA = 1'b1;

endpackage

// File: rtl/h_alpha_elem_ram.sv
// Alpha element store: simple dual-port RAM, synchronous write and registered read.
// The read register doubles as the alpha output register of the stream source.
module h_alpha_elem_ram #(
  parameter int unsigned Depth = 28,
  parameter int unsigned Width = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Write port plus registered read; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/h_alpha_stream_src.sv
// Streams the I rows of H, then the A alpha columns (J elements each, column-major),
// over two AXI-Stream style ports, once per start pulse. Both stores are loaded
// through a small config port that is only live while idle.
module h_alpha_stream_src
  import h_alpha_stream_src_pkg::*;
#(
  parameter int unsigned J  = 14,
  parameter int unsigned I  = 2,
  parameter int unsigned A  = 2,
  parameter int unsigned DW = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [$clog2(J*A):0]  cfg_addr,
  input  logic [DW-1:0]         cfg_wdata,
  output logic [J-1:0]          H_row,
  output logic                  H_row_tvalid,
  input  logic                  H_row_tready,
  output logic                  H_row_tlast,
  output logic [DW-1:0]         alpha_u_col,
  output logic                  alpha_u_col_tvalid,
  input  logic                  alpha_u_col_tready,
  output logic                  alpha_u_col_tlast
);

  localparam int unsigned N  = J * A;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned AW = $clog2(N);

  state_t          state_q, state_d;
  logic [CW-1:0]   h_cnt_q, h_cnt_d;   // H row index
  logic [CW-1:0]   a_cnt_q, a_cnt_d;   // flat alpha element index
  logic [CW-1:0]   elem_q, elem_d;     // element index within the current column

  logic            h_acc, a_acc;
  logic            h_last_row, a_last_elem;

  logic            cfg_ok, h_wr, a_wr;
  logic [J-1:0]    h_mem [I];
  logic [J-1:0]    h_row_sel;
  logic [DW-1:0]   ram_rdata;

  assign h_acc       = H_row_tvalid & H_row_tready;
  assign a_acc       = alpha_u_col_tvalid & alpha_u_col_tready;
  assign h_last_row  = (h_cnt_q == CW'(I - 1));
  assign a_last_elem = (a_cnt_q == CW'(N - 1));

  // Next-state and counter logic; every state entry starts its counters from zero.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    a_cnt_d = a_cnt_q;
    elem_d  = elem_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        a_cnt_d = '0;
        elem_d  = '0;
        if (start) begin
          state_d = ST_SEND_H;
        end
      end
      ST_SEND_H: begin
        if (h_acc) begin
          if (h_last_row) begin
            state_d = ST_SEND_A;
            h_cnt_d = '0;
            a_cnt_d = '0;
            elem_d  = '0;
          end else begin
            h_cnt_d = h_cnt_q + CW'(1);
          end
        end
      end
      ST_SEND_A: begin
        if (a_acc) begin
          if (a_last_elem) begin
            state_d = ST_FIN;
            a_cnt_d = '0;
            elem_d  = '0;
          end else begin
            a_cnt_d = a_cnt_q + CW'(1);
            elem_d  = (elem_q == CW'(J - 1)) ? '0 : elem_q + CW'(1);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        h_cnt_d = '0;
        a_cnt_d = '0;
        elem_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        h_cnt_d = '0;
        a_cnt_d = '0;
        elem_d  = '0;
      end
    endcase
  end

  // State and counter registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      a_cnt_q <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      a_cnt_q <= a_cnt_d;
      elem_q  <= elem_d;
    end
  end

  // Status and handshake outputs are pure decodes of registered state, so an
  // asynchronous reset clears them in the same cycle.
  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_FIN);
  assign H_row_tvalid       = (state_q == ST_SEND_H);
  assign H_row_tlast        = H_row_tvalid & h_last_row;
  assign alpha_u_col_tvalid = (state_q == ST_SEND_A);
  assign alpha_u_col_tlast  = alpha_u_col_tvalid & (elem_q == CW'(J - 1));

  // Config writes land only while idle and only for in-range addresses. A write
  // in the same cycle as start lands at that edge, ahead of the first read.
  assign cfg_ok = cfg_we & (state_q == ST_IDLE);
  assign h_wr   = cfg_ok & (cfg_sel == SEL_H)     & (cfg_addr < CW'(I));
  assign a_wr   = cfg_ok & (cfg_sel == SEL_ALPHA) & (cfg_addr < CW'(N));

  // H row store; retains contents across reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(I); r++) begin
      if (h_wr && (cfg_addr == CW'(r))) begin
        h_mem[r] <= cfg_wdata[J-1:0];
      end
    end
  end

  // Select the current H row; the counter is frozen during a stall so the row holds.
  always_comb begin
    h_row_sel = '0;
    for (int r = 0; r < int'(I); r++) begin
      if (h_cnt_q == CW'(r)) begin
        h_row_sel = h_mem[r];
      end
    end
  end

  assign H_row = H_row_tvalid ? h_row_sel : '0;

  // The RAM is addressed with the next element index, so its read register holds
  // the element for the following cycle. During SEND_H the index is parked at 0,
  // which has element 0 ready on the first alpha cycle with no bubble.
  h_alpha_elem_ram #(
    .Depth (N),
    .Width (DW),
    .AddrW (AW)
  ) u_elem_ram (
    .clk   (clk),
    .we    (a_wr),
    .waddr (cfg_addr[AW-1:0]),
    .wdata (cfg_wdata),
    .raddr (a_cnt_d[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign alpha_u_col = alpha_u_col_tvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_h_alpha_stream_src.sv
// Self-checking bench for h_alpha_stream_src: table of config writes, table of
// transfer scenarios, and a queue-based reference of the expected stream.
module tb_h_alpha_stream_src;
  import h_alpha_stream_src_pkg::*;

  localparam int unsigned J  = 14;
  localparam int unsigned I  = 2;
  localparam int unsigned A  = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned N  = J * A;
  localparam int unsigned CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, cfg_we, cfg_sel;
  logic [CW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic [J-1:0]  H_row;
  logic          H_row_tvalid, H_row_tready, H_row_tlast;
  logic [DW-1:0] alpha_u_col;
  logic          alpha_u_col_tvalid, alpha_u_col_tready, alpha_u_col_tlast;

  int total = 0;
  int bad   = 0;

  // Reference contents of both stores.
  logic [J-1:0]  h_ref [I];
  logic [DW-1:0] a_ref [N];

  always #5 clk = ~clk;

  h_alpha_stream_src #(.J(J), .I(I), .A(A), .DW(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .cfg_we             (cfg_we),
    .cfg_sel            (cfg_sel),
    .cfg_addr           (cfg_addr),
    .cfg_wdata          (cfg_wdata),
    .H_row              (H_row),
    .H_row_tvalid       (H_row_tvalid),
    .H_row_tready       (H_row_tready),
    .H_row_tlast        (H_row_tlast),
    .alpha_u_col        (alpha_u_col),
    .alpha_u_col_tvalid (alpha_u_col_tvalid),
    .alpha_u_col_tready (alpha_u_col_tready),
    .alpha_u_col_tlast  (alpha_u_col_tlast)
  );

  typedef struct {
    logic          sel;
    int            addr;
    logic [DW-1:0] data;
    bit            applied;
  } cfg_vec_t;

  typedef struct {
    bit            h_rand;
    bit            a_rand;
    int            h_hold;       // cycles to stall row 0
    int            extra_start;  // cycle of a start pulse while busy (-1 none)
    int            busy_wr;      // cycle of a config write while busy (-1 none)
    int            rst_elem;     // alpha element at which to reset (-1 none)
    bit            timing;       // check exact latencies (full-rate only)
    bit            wr;           // config write together with start
    logic          sel;
    int            wr_addr;
    logic [DW-1:0] wr_data;
  } xfer_t;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rule for an idle config write.
  function automatic void model_write(input logic sel, input int addr, input logic [DW-1:0] d);
    if (sel == SEL_H) begin
      if (addr >= 0 && addr < int'(I)) h_ref[addr] = d[J-1:0];
    end else if (addr >= 0 && addr < int'(N)) begin
      a_ref[addr] = d;
    end
  endfunction

  task automatic cfg_write(input logic sel, input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = CW'(addr);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic run_xfer(input int id, input xfer_t x);
    logic [J-1:0]  h_got [$];
    bit            h_lst [$];
    logic [DW-1:0] a_got [$];
    bit            a_lst [$];
    logic [J+1:0]  h_prev;
    logic [DW+1:0] a_prev;
    int cyc, n_done, t_done, t_h0, t_a0, hold_left, nl;
    bit fin, aborted, h_st, a_st;
    string p;
    p = $sformatf("x%0d", id);
    n_done = 0; t_done = -1; t_h0 = -1; t_a0 = -1; hold_left = x.h_hold;
    fin = 1'b0; aborted = 1'b0; h_st = 1'b0; a_st = 1'b0;
    h_prev = '0; a_prev = '0;
    @(negedge clk);
    start = 1'b1;
    if (x.wr) begin
      cfg_we    = 1'b1;
      cfg_sel   = x.sel;
      cfg_addr  = CW'(x.wr_addr);
      cfg_wdata = x.wr_data;
      model_write(x.sel, x.wr_addr, x.wr_data);
    end
    cyc = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      cfg_we = 1'b0;
      if (x.rst_elem >= 0 && alpha_u_col_tvalid && a_got.size() == x.rst_elem) begin
        rst = 1'b1;
        #1;
        check_vec({p, ".rst_ctl"},
                  {124'd0, busy, done, H_row_tvalid, alpha_u_col_tvalid}, '0);
        check_vec({p, ".rst_last"}, {126'd0, H_row_tlast, alpha_u_col_tlast}, '0);
        check_vec({p, ".rst_h"}, {114'd0, H_row}, '0);
        check_vec({p, ".rst_a"}, {64'd0, alpha_u_col}, '0);
        @(negedge clk);
        check_int({p, ".rst_done"}, int'(done), 0);
        rst = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        check_int({p, ".overlap"}, int'(H_row_tvalid & alpha_u_col_tvalid), 0);
        if (!H_row_tvalid) check_vec({p, ".h_zero"}, {113'd0, H_row_tlast, H_row}, '0);
        if (!alpha_u_col_tvalid)
          check_vec({p, ".a_zero"}, {63'd0, alpha_u_col_tlast, alpha_u_col}, '0);
        if (h_st) check_vec({p, ".h_stable"}, {112'd0, H_row_tvalid, H_row_tlast, H_row},
                            {112'd0, h_prev});
        if (a_st) check_vec({p, ".a_stable"},
                            {62'd0, alpha_u_col_tvalid, alpha_u_col_tlast, alpha_u_col},
                            {62'd0, a_prev});
        if (t_done < 0 && !done) check_int({p, ".busy"}, int'(busy), 1);
        if (H_row_tvalid && t_h0 < 0) t_h0 = cyc;
        if (alpha_u_col_tvalid && t_a0 < 0) t_a0 = cyc;
        // Ready choice for the coming edge.
        if (H_row_tvalid && hold_left > 0 && h_got.size() == 0) begin
          H_row_tready = 1'b0;
          hold_left--;
          check_vec({p, ".hold_row"}, {114'd0, H_row}, {114'd0, h_ref[0]});
        end else begin
          H_row_tready = x.h_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        alpha_u_col_tready = x.a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        h_st   = H_row_tvalid & ~H_row_tready;
        h_prev = {H_row_tvalid, H_row_tlast, H_row};
        a_st   = alpha_u_col_tvalid & ~alpha_u_col_tready;
        a_prev = {alpha_u_col_tvalid, alpha_u_col_tlast, alpha_u_col};
        if (H_row_tvalid && H_row_tready) begin
          h_got.push_back(H_row);
          h_lst.push_back(H_row_tlast);
        end
        if (alpha_u_col_tvalid && alpha_u_col_tready) begin
          a_got.push_back(alpha_u_col);
          a_lst.push_back(alpha_u_col_tlast);
        end
        if (cyc == x.extra_start) start = 1'b1;
        if (cyc == x.busy_wr) begin
          cfg_we    = 1'b1;
          cfg_sel   = SEL_ALPHA;
          cfg_addr  = CW'(5);
          cfg_wdata = 64'hDEAD_BEEF_0000_0005;
        end
        if (t_done >= 0 && cyc == t_done + 1) begin
          check_int({p, ".post_done"}, int'(done), 0);
          check_int({p, ".post_busy"}, int'(busy), 0);
          fin = 1'b1;
        end
        if (done) begin
          n_done++;
          if (t_done < 0) t_done = cyc;
        end
        if (cyc >= 400 && !fin) begin
          check_int({p, ".timeout_done"}, n_done, 1);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    cfg_we = 1'b0;
    H_row_tready = 1'b1;
    alpha_u_col_tready = 1'b1;
    if (aborted) begin
      check_int({p, ".abort_done"}, n_done, 0);
      check_int({p, ".abort_n_a"}, a_got.size(), x.rst_elem);
      for (int k = 0; k < a_got.size() && k < int'(N); k++)
        check_vec({p, $sformatf(".abort_a%0d", k)}, {64'd0, a_got[k]}, {64'd0, a_ref[k]});
    end else begin
      check_int({p, ".n_h"}, h_got.size(), int'(I));
      for (int r = 0; r < h_got.size() && r < int'(I); r++) begin
        check_vec({p, $sformatf(".h%0d", r)}, {114'd0, h_got[r]}, {114'd0, h_ref[r]});
        check_int({p, $sformatf(".hlast%0d", r)}, int'(h_lst[r]), int'(r == int'(I) - 1));
      end
      check_int({p, ".n_a"}, a_got.size(), int'(N));
      nl = 0;
      for (int k = 0; k < a_got.size() && k < int'(N); k++) begin
        check_vec({p, $sformatf(".a%0d", k)}, {64'd0, a_got[k]}, {64'd0, a_ref[k]});
        check_int({p, $sformatf(".alast%0d", k)}, int'(a_lst[k]),
                  int'((k % int'(J)) == int'(J) - 1));
        if (a_lst[k]) nl++;
      end
      check_int({p, ".a_last_cnt"}, nl, int'(A));
      check_int({p, ".n_done"}, n_done, 1);
      if (x.timing) begin
        check_int({p, ".t_h0"}, t_h0, 1);
        check_int({p, ".t_a0"}, t_a0, int'(I) + 1);
        check_int({p, ".t_done"}, t_done, int'(I + N) + 1);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  cfg_vec_t cv [6];
  xfer_t    xt [11];

  initial begin
    cv[0] = '{SEL_H,     0,  64'h0001, 1'b1};
    cv[1] = '{SEL_H,     1,  64'h2000, 1'b1};
    cv[2] = '{SEL_H,     2,  64'h3FFF, 1'b0};
    cv[3] = '{SEL_H,     3,  64'h1234, 1'b0};
    cv[4] = '{SEL_ALPHA, 28, 64'hBAD0_0028, 1'b0};
    cv[5] = '{SEL_ALPHA, 32, 64'hBAD0_0032, 1'b0};

    //        hr    ar    hold xs  bw  re  tim   wr    sel        addr data
    xt[0]  = '{1'b0, 1'b0, 0, -1, -1, -1, 1'b1, 1'b0, SEL_H,     0,  64'h0};
    xt[1]  = '{1'b0, 1'b0, 5, -1, -1, -1, 1'b0, 1'b0, SEL_H,     0,  64'h0};
    xt[2]  = '{1'b0, 1'b1, 0, -1, -1, -1, 1'b0, 1'b0, SEL_H,     0,  64'h0};
    xt[3]  = '{1'b1, 1'b0, 0, 10, -1, -1, 1'b0, 1'b0, SEL_H,     0,  64'h0};
    xt[4]  = '{1'b0, 1'b0, 0, -1,  8, -1, 1'b1, 1'b0, SEL_H,     0,  64'h0};
    xt[5]  = '{1'b0, 1'b0, 0, -1, -1,  7, 1'b0, 1'b0, SEL_H,     0,  64'h0};
    xt[6]  = '{1'b0, 1'b0, 0, -1, -1, -1, 1'b1, 1'b0, SEL_H,     0,  64'h0};
    xt[7]  = '{1'b0, 1'b0, 0, -1, -1, -1, 1'b1, 1'b1, SEL_ALPHA, 3,  64'hABCD_0003};
    xt[8]  = '{1'b0, 1'b0, 0, -1, -1, -1, 1'b1, 1'b1, SEL_H,     1,  64'h1555};
    xt[9]  = '{1'b1, 1'b1, 0, -1, -1, -1, 1'b0, 1'b0, SEL_H,     0,  64'h0};
    xt[10] = '{1'b1, 1'b1, 2, 15, 20, -1, 1'b0, 1'b1, SEL_ALPHA, 27, 64'hFFFF_FFFF_FFFF_FFFF};

    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    H_row_tready = 1'b1; alpha_u_col_tready = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("reset_ctl", {124'd0, busy, done, H_row_tvalid, alpha_u_col_tvalid}, '0);
    check_vec("reset_last", {126'd0, H_row_tlast, alpha_u_col_tlast}, '0);
    check_vec("reset_data", {50'd0, H_row, alpha_u_col}, '0);
    rst = 1'b0;

    for (int k = 0; k < int'(N); k++) begin
      cfg_write(SEL_ALPHA, k, DW'(k));
      a_ref[k] = DW'(k);
    end
    for (int v = 0; v < 6; v++) begin
      cfg_write(cv[v].sel, cv[v].addr, cv[v].data);
      if (cv[v].applied) begin
        if (cv[v].sel == SEL_H) h_ref[cv[v].addr] = cv[v].data[J-1:0];
        else a_ref[cv[v].addr] = cv[v].data;
      end
    end

    for (int s = 0; s < 11; s++) run_xfer(s, xt[s]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/h_alpha_stream_src.md
H_ALPHA_STREAM_SRC -- requirements
Module: h_alpha_stream_src

Interface
REQ-001 SHALL have parameter J, default 14: number of columns of H, which is also the length of each alpha_u column.
REQ-002 SHALL have parameter I, default 2: number of H rows.
REQ-003 SHALL have parameter A, default 2: number of alpha_u columns.
REQ-004 SHALL have parameter DW, default 64: alpha element width (IEEE-754 double bit pattern, passed through opaque).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that launches a transfer.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse after the last alpha beat is accepted.
REQ-010 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-011 SHALL have port cfg_sel, input, 1: 0 = H row store, 1 = alpha store.
REQ-012 SHALL have port cfg_addr, input, $clog2(J*A)+1: for H, row index; for alpha, col*J + element index.
REQ-013 SHALL have port cfg_wdata, input, DW: for H, low J bits are the row; for alpha, one element.
REQ-014 SHALL have port H_row, output, J: current H row.
REQ-015 SHALL have ports H_row_tvalid (output, 1), H_row_tready (input, 1) and H_row_tlast (output, 1): AXI-Stream handshake for H_row.
REQ-016 SHALL have port alpha_u_col, output, DW: current alpha element.
REQ-017 SHALL have ports alpha_u_col_tvalid (output, 1), alpha_u_col_tready (input, 1) and alpha_u_col_tlast (output, 1): AXI-Stream handshake for alpha_u_col.

Function
REQ-018 SHALL implement FSM states IDLE, SEND_H, SEND_A and FIN.
REQ-019 SHALL make these transitions: IDLE->SEND_H on start; SEND_H->SEND_A on accept of H beat I-1; SEND_A->FIN on accept of alpha beat J*A-1; FIN->IDLE unconditionally.
REQ-020 SHALL assert done only in FIN, for exactly one cycle.
REQ-021 SHALL ignore start while not in IDLE, with no queuing.
REQ-022 SHALL assert H_row_tvalid the cycle after start is accepted (latency 1).
REQ-023 SHALL present row r=0..I-1 in order on H_row.
REQ-024 SHALL assert H_row_tlast only with row I-1.
REQ-025 SHALL count a beat as accepted when tvalid & tready.
REQ-026 SHALL hold H_row, tvalid and tlast stable while tvalid is high and tready is low.
REQ-027 SHALL present the next beat in the cycle following acceptance, sustaining one beat per cycle when tready is held high.
REQ-028 SHALL raise alpha_u_col_tvalid in the cycle after H_row tlast is accepted, with no overlap of the two streams.
REQ-029 SHALL emit alpha elements column-major (col 0 elements 0..J-1, then col 1, and so on).
REQ-030 SHALL assert alpha_u_col_tlast on element J-1 of every column, i.e. A times per transfer.
REQ-031 SHALL deassert both tvalid signals in IDLE and FIN.
REQ-032 SHALL drive H_row and alpha_u_col to zero whenever the corresponding tvalid is low.
REQ-033 SHALL perform config writes only in IDLE and ignore them while busy.
REQ-034 SHALL ignore writes with an out-of-range address (H: >= I; alpha: >= J*A).
REQ-035 SHALL accept a config write and a start in the same IDLE cycle, with the write landing first so the transfer sees the new data.
REQ-036 SHALL implement the beat counters as saturating-free up-counters sized $clog2(J*A)+1 that clear on each state entry.

Reset
REQ-037 SHALL, on rst, immediately force the FSM to IDLE, clear all counters, and drive every output (busy, done, both tvalid, both tlast, H_row, alpha_u_col) to 0.
REQ-038 SHALL abort any transfer in progress on a mid-transfer rst, with no done pulse.
REQ-039 SHALL leave storage contents unreset: H and alpha stores retain data across rst.

Structure
REQ-040 SHALL place the FSM state encoding and the cfg_sel encodings (SEL_H=0, SEL_ALPHA=1) in a shared package, which the downstream consumer also imports.
REQ-041 SHALL implement the alpha store as one sub-module, h_alpha_elem_ram: a J*A x DW synchronous-read RAM.
REQ-042 SHALL register the RAM read so that it feeds the output register without adding a bubble at the H->alpha boundary.

Verification
REQ-043 SHALL cover the baseline transfer: load H rows 14'h0001 and 14'h2000, load alpha[k]=k, pulse start with both treadys high -> H beats in cycles 1-2 (tlast on 2nd), alpha 0..27 in cycles 3-30, tlast at elements 13 and 27, done in cycle 31.
REQ-044 SHALL cover backpressure: hold H_row_tready low for 5 cycles on row 0 -> H_row stays 14'h0001 with tvalid high throughout; every beat is still delivered exactly once.
REQ-045 SHALL cover random tready toggling on alpha -> the sequence received is exactly 0..27 with no duplicates and tlast count 2.
REQ-046 SHALL cover start while busy: a second start in the middle of the transfer -> ignored, exactly one done.
REQ-047 SHALL cover reset mid-transfer: assert rst at alpha element 7 -> all outputs 0 within the same cycle, no done; the next start replays the full stream with the stored data intact.
REQ-048 SHALL cover config boundaries: a cfg write while busy is not applied; a write with alpha address 28 is ignored; a write plus start in the same cycle -> the new value appears in the stream.
